// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge.
//   - apb_state_e : bridge FSM states
//   - F3_*        : RV32I load/store funct3 encodings carried on ramControl
//   - REGION_LSB / SLAVE_SEL_LSB : address bit positions for region and slave decode
//   - funct3_supported : true for the five access sizes the bridge implements
//   - is_misaligned    : true when the access crosses its natural alignment
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // 16 KiB peripheral region: bits [31:14] identify the region,
    // bits [13:12] pick one of up to four 4 KiB slave windows.
    localparam int REGION_LSB    = 14;
    localparam int SLAVE_SEL_LSB = 12;

    function automatic logic funct3_supported(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            mis = lo[0];
        end else if (f3 == F3_W) begin
            mis = (lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/apb_master_bridge_lane_align.sv
// bus_lane_align: combinational byte-lane handling between the CPU side and APB.
// Ports:
//   we        in   1  store (1) or load (0)
//   ctrl      in   3  funct3 access size / signedness
//   addr_lo   in   2  byte offset within the word
//   wdata     in  32  right-justified store data
//   prdata    in  32  raw word returned by the selected slave
//   pwdata    out 32  store data replicated across lanes (0 for loads)
//   pstrb     out  4  byte strobes (0 for loads)
//   load_data out 32  extracted and sign/zero-extended load result
module bus_lane_align
    import apb_master_bridge_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] prdata,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [31:0] load_data
);

    // Store path: sub-word data is copied into every lane so the slave can
    // pick it up from whichever lane the strobes enable.
    always_comb begin
        pwdata = 32'h0;
        pstrb  = 4'b0000;
        if (we) begin
            case (ctrl)
                F3_B: begin
                    pwdata = {4{wdata[7:0]}};
                    pstrb  = 4'b0001 << addr_lo;
                end
                F3_H: begin
                    pwdata = {2{wdata[15:0]}};
                    pstrb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    pwdata = wdata;
                    pstrb  = 4'b1111;
                end
            endcase
        end
    end

    // Load path: pull the addressed byte/half down to bit 0 and extend it.
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte = prdata[8*addr_lo +: 8];
        lane_half = addr_lo[1] ? prdata[31:16] : prdata[15:0];
        case (ctrl)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'h0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'h0, lane_half};
            default: load_data = prdata;
        endcase
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single CPU load/store requests into APB transfers.
// Ports:
//   clk, reset (async, active-low)
//   busReq/busWe/busAddr/busWData/ramControl  CPU request (held until busReady)
//   busRData/busReady/busErr                  CPU completion (one-cycle pulse)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB    APB request side
//   PRDATA/PREADY/PSLVERR                     per-slave APB returns, slave i at [32i+31:32i]
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     busReq,
    input  logic                     busWe,
    input  logic [31:0]              busAddr,
    input  logic [31:0]              busWData,
    input  logic [2:0]               ramControl,
    output logic [31:0]              busRData,
    output logic                     busReady,
    output logic                     busErr,
    output logic [31:0]              PADDR,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic [3:0]               PSTRB,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);

    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  SLAVE_LIM = 3'(NUM_SLAVES);

    apb_state_e        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        sel;
    logic              req_ok;
    logic              active;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_strb;
    logic [31:0]       load_data;

    assign sel = addr_q[SLAVE_SEL_LSB +: 2];

    // A request goes out on APB only if it hits an existing slave window with
    // a supported, naturally aligned access; anything else fails at decode.
    assign req_ok = (busAddr[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB]) &&
                    ({1'b0, busAddr[SLAVE_SEL_LSB +: 2]} < SLAVE_LIM) &&
                    funct3_supported(ramControl) &&
                    !is_misaligned(ramControl, busAddr[1:0]);

    bus_lane_align u_lane_align (
        .we        (we_q),
        .ctrl      (ctrl_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .prdata    (PRDATA[32*sel +: 32]),
        .pwdata    (lane_wdata),
        .pstrb     (lane_strb),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ctrl_q  <= 3'b000;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields are captured only when leaving IDLE, so the CPU may
    // change its bus freely while the transfer is in flight.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (busReq) begin
                    if (req_ok) begin
                        state_d = ST_SETUP;
                        addr_d  = busAddr;
                        wdata_d = busWData;
                        ctrl_d  = ramControl;
                        we_d    = busWe;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY[sel]) begin
                    state_d = ST_DONE;
                    err_d   = PSLVERR[sel];
                    rdata_d = we_q ? 32'h0 : load_data;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed wait cycle has passed without PREADY.
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // APB request outputs are forced to zero outside SETUP/ACCESS so the bus
    // is quiet in IDLE/DONE and immediately after reset.
    assign active   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PSEL     = active ? (NUM_SLAVES'(1) << sel) : '0;
    assign PENABLE  = (state_q == ST_ACCESS);
    assign PADDR    = active ? {addr_q[31:2], 2'b00} : 32'h0;
    assign PWRITE   = active & we_q;
    assign PWDATA   = active ? lane_wdata : 32'h0;
    assign PSTRB    = active ? lane_strb : 4'b0000;

    assign busReady = (state_q == ST_DONE);
    assign busErr   = (state_q == ST_DONE) & err_q;
    assign busRData = rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge. The bench plays the CPU and a
// simple per-slave APB responder; expected values are hand-computed.
module tb_apb_master_bridge;

    logic         clk;
    logic         reset;
    logic         busReq;
    logic         busWe;
    logic [31:0]  busAddr;
    logic [31:0]  busWData;
    logic [2:0]   ramControl;
    logic [31:0]  busRData;
    logic         busReady;
    logic         busErr;
    logic [31:0]  PADDR;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;

    int assertCount = 0;
    int failCount   = 0;

    // Snapshot of one transfer, filled by applyStimulus.
    int          cycles;
    logic        selSeen;
    logic [3:0]  setupPsel;
    logic [3:0]  setupPstrb;
    logic [31:0] setupPaddr;
    logic [31:0] setupPwdata;
    logic        setupPwrite;
    logic        setupPenable;
    logic        accessPenable;
    logic        doneErr;
    logic [31:0] doneRdata;

    apb_master_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .busReq     (busReq),
        .busWe      (busWe),
        .busAddr    (busAddr),
        .busWData   (busWData),
        .ramControl (ramControl),
        .busRData   (busRData),
        .busReady   (busReady),
        .busErr     (busErr),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one CPU request and run the slave model until busReady (bounded).
    // The addressed slave returns rdVal/slvErr and raises PREADY from the
    // cycle numbered readyAt onward; cycle 1 is the first cycle after the
    // request edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] ctrl, input logic [31:0] rdVal,
                                 input logic slvErr, input int readyAt);
        int  slot;
        logic done;
        slot = int'(addr[13:12]);
        @(negedge clk);
        busReq     = 1'b1;
        busWe      = we;
        busAddr    = addr;
        busWData   = wdata;
        ramControl = ctrl;
        PRDATA     = {4{32'hA5A5_A5A5}};
        PRDATA[32*slot +: 32] = rdVal;
        PSLVERR    = slvErr ? (4'b0001 << slot) : 4'b0000;
        PREADY     = (readyAt <= 0) ? (4'b0001 << slot) : 4'b0000;
        cycles     = 0;
        selSeen    = 1'b0;
        done       = 1'b0;
        doneErr    = 1'b0;
        doneRdata  = 32'hxxxx_xxxx;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (PSEL != 4'b0000) selSeen = 1'b1;
            if (cycles == 1) begin
                setupPsel    = PSEL;
                setupPstrb   = PSTRB;
                setupPaddr   = PADDR;
                setupPwdata  = PWDATA;
                setupPwrite  = PWRITE;
                setupPenable = PENABLE;
            end
            if (cycles == 2) accessPenable = PENABLE;
            if (busReady) begin
                done      = 1'b1;
                doneErr   = busErr;
                doneRdata = busRData;
                busReq    = 1'b0;
            end
            PREADY = (cycles >= readyAt) ? (4'b0001 << slot) : 4'b0000;
        end
        busReq = 1'b0;
        PREADY = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        busReq     = 1'b0;
        busWe      = 1'b0;
        busAddr    = 32'h0;
        busWData   = 32'h0;
        ramControl = 3'b000;
        PRDATA     = '0;
        PREADY     = 4'b0000;
        PSLVERR    = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busReady", 32'(busReady), 32'h0);
        checkOutput("rst_busErr",   32'(busErr),   32'h0);
        checkOutput("rst_busRData", busRData,      32'h0);
        checkOutput("rst_psel",     32'(PSEL),     32'h0);
        checkOutput("rst_penable",  32'(PENABLE),  32'h0);
        checkOutput("rst_paddr",    PADDR,         32'h0);
        @(negedge clk);
        reset = 1'b1;

        // SW to slave 1, immediate PREADY
        applyStimulus(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 0);
        checkOutput("sw_cycles",  32'(cycles),       32'd3);
        checkOutput("sw_psel",    32'(setupPsel),    32'h2);
        checkOutput("sw_pstrb",   32'(setupPstrb),   32'hF);
        checkOutput("sw_pwdata",  setupPwdata,       32'hDEAD_BEEF);
        checkOutput("sw_paddr",   setupPaddr,        32'h1000_1004);
        checkOutput("sw_pwrite",  32'(setupPwrite),  32'h1);
        checkOutput("sw_setup_penable",  32'(setupPenable),  32'h0);
        checkOutput("sw_access_penable", 32'(accessPenable), 32'h1);
        checkOutput("sw_err",     32'(doneErr),      32'h0);
        checkOutput("sw_rdata",   doneRdata,         32'h0);

        // LB / LBU from lane 3 of slave 0
        applyStimulus(1'b0, 32'h1000_0003, 32'h0, 3'b000, 32'h80FF_FF7F, 1'b0, 0);
        checkOutput("lb_rdata",  doneRdata,          32'hFFFF_FF80);
        checkOutput("lb_pstrb",  32'(setupPstrb),    32'h0);
        checkOutput("lb_paddr",  setupPaddr,         32'h1000_0000);
        checkOutput("lb_psel",   32'(setupPsel),     32'h1);
        checkOutput("lb_pwrite", 32'(setupPwrite),   32'h0);
        checkOutput("lb_hold",   busRData,           32'hFFFF_FF80);
        applyStimulus(1'b0, 32'h1000_0003, 32'h0, 3'b100, 32'h80FF_FF7F, 1'b0, 0);
        checkOutput("lbu_rdata", doneRdata,          32'h0000_0080);

        // SH to upper half of slave 2, then misaligned LH
        applyStimulus(1'b1, 32'h1000_2002, 32'h0000_ABCD, 3'b001, 32'h0, 1'b0, 0);
        checkOutput("sh_pwdata", setupPwdata,        32'hABCD_ABCD);
        checkOutput("sh_pstrb",  32'(setupPstrb),    32'hC);
        checkOutput("sh_psel",   32'(setupPsel),     32'h4);
        applyStimulus(1'b0, 32'h1000_2001, 32'h0, 3'b001, 32'h1234_5678, 1'b0, 0);
        checkOutput("lh_mis_cycles", 32'(cycles),    32'd1);
        checkOutput("lh_mis_err",    32'(doneErr),   32'h1);
        checkOutput("lh_mis_psel",   32'(selSeen),   32'h0);

        // SB lane 1 of slave 0
        applyStimulus(1'b1, 32'h1000_0001, 32'h0000_005A, 3'b000, 32'h0, 1'b0, 0);
        checkOutput("sb_pwdata", setupPwdata,        32'h5A5A_5A5A);
        checkOutput("sb_pstrb",  32'(setupPstrb),    32'h2);

        // LHU upper half with slave error
        applyStimulus(1'b0, 32'h1000_0002, 32'h0, 3'b101, 32'hBEEF_1234, 1'b1, 0);
        checkOutput("lhu_rdata", doneRdata,          32'h0000_BEEF);
        checkOutput("lhu_slverr", 32'(doneErr),      32'h1);

        // LH sign extension from lower half
        applyStimulus(1'b0, 32'h1000_1000, 32'h0, 3'b001, 32'h0000_8001, 1'b0, 0);
        checkOutput("lh_rdata", doneRdata,           32'hFFFF_8001);

        // Decode errors: outside region, reserved funct3
        applyStimulus(1'b0, 32'h2000_0000, 32'h0, 3'b010, 32'h0, 1'b0, 0);
        checkOutput("dec_region_cycles", 32'(cycles), 32'd1);
        checkOutput("dec_region_err",    32'(doneErr), 32'h1);
        checkOutput("dec_region_psel",   32'(selSeen), 32'h0);
        applyStimulus(1'b0, 32'h1000_0000, 32'h0, 3'b011, 32'h0, 1'b0, 0);
        checkOutput("dec_f3_err",    32'(doneErr), 32'h1);
        checkOutput("dec_f3_rdata",  doneRdata,    32'h0);

        // LW slave 3: timeout, then delayed PREADY
        applyStimulus(1'b0, 32'h1000_3000, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, 1000);
        checkOutput("lw_to_cycles", 32'(cycles),    32'd18);
        checkOutput("lw_to_err",    32'(doneErr),   32'h1);
        checkOutput("lw_to_rdata",  doneRdata,      32'h0);
        checkOutput("lw_to_psel",   32'(setupPsel), 32'h8);
        applyStimulus(1'b0, 32'h1000_3000, 32'h0, 3'b010, 32'h1234_5678, 1'b0, 7);
        checkOutput("lw_wait_cycles", 32'(cycles),  32'd8);
        checkOutput("lw_wait_err",    32'(doneErr), 32'h0);
        checkOutput("lw_wait_rdata",  doneRdata,    32'h1234_5678);

        // Reset asserted while in ACCESS
        @(negedge clk);
        busReq     = 1'b1;
        busWe      = 1'b0;
        busAddr    = 32'h1000_0000;
        ramControl = 3'b010;
        PREADY     = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_access_penable", 32'(PENABLE), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_psel",     32'(PSEL),     32'h0);
        checkOutput("mid_rst_penable",  32'(PENABLE),  32'h0);
        checkOutput("mid_rst_busReady", 32'(busReady), 32'h0);
        busReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h1000_1008, 32'h0, 3'b010, 32'h0BAD_F00D, 1'b0, 0);
        checkOutput("post_rst_cycles", 32'(cycles), 32'd3);
        checkOutput("post_rst_rdata",  doneRdata,   32'h0BAD_F00D);
        checkOutput("post_rst_err",    32'(doneErr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter NUM_SLAVES, default 4, meaning number of APB slaves (PSEL width), max 4.
REQ-002 Parameter TIMEOUT, default 16, meaning ACCESS cycles allowed before abort.
REQ-003 Parameter BASE_ADDR, default 32'h1000_0000, meaning peripheral region base (16 KiB region).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 busReq  input  1  CPU transfer request, held by CPU until busReady.
REQ-007 busWe  input  1  1=store, 0=load.
REQ-008 busAddr  input  32  byte address.
REQ-009 busWData  input  32  store data, right-justified (byte/half in low bits).
REQ-010 ramControl  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 busRData  output  32  load data, aligned and sign/zero-extended.
REQ-012 busReady  output  1  one-cycle completion pulse.
REQ-013 busErr  output  1  valid with busReady; 1=decode/misalign/slave error/timeout.
REQ-014 PADDR  output  32  APB address, word-aligned (busAddr[31:2],2'b00).
REQ-015 PSEL  output  NUM_SLAVES  one-hot slave select.
REQ-016 PENABLE, PWRITE  output  1 each  APB phase/direction.
REQ-017 PWDATA  output  32; PSTRB  output  4  lane-replicated data, byte strobes.
REQ-018 PRDATA  input  NUM_SLAVES*32; PREADY, PSLVERR  input  NUM_SLAVES each  per-slave returns, slave i at bits [32i+31:32i].

Function
REQ-019 States IDLE, SETUP, ACCESS, DONE; DONE always returns to IDLE.
REQ-020 IDLE + busReq: decode; valid and aligned -> SETUP, else -> DONE with busErr=1, no APB activity.
REQ-021 Decode: busAddr[31:14]==BASE_ADDR[31:14] and busAddr[13:12]<NUM_SLAVES, else decode error.
REQ-022 Misalign: H/HU with addr[0]=1, W with addr[1:0]!=0.
REQ-023 Request fields latched on IDLE->SETUP; later busReq/busAddr changes ignored until DONE.
REQ-024 SETUP: PSEL[addr[13:12]]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid; next state ACCESS unconditionally.
REQ-025 ACCESS: PENABLE=1, outputs stable; PREADY of selected slave=1 -> DONE, capture PRDATA and PSLVERR.
REQ-026 Timeout counter clears on SETUP, increments each ACCESS cycle without PREADY; TIMEOUT cycles reached -> DONE, busErr=1, busRData=0.
REQ-027 DONE: busReady=1 for exactly one cycle, busRData/busErr registered; PSEL=0, PENABLE=0.
REQ-028 Minimum latency request->busReady: 3 cycles (SETUP, ACCESS, DONE); error-at-decode: 1 cycle.
REQ-029 Stores: B replicates byte to all lanes, PSTRB=1<<addr[1:0]; H replicates half, PSTRB=addr[1]?1100:0011; W PSTRB=1111.
REQ-030 Loads: PSTRB=0000; byte/half extracted from lane addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-031 Reserved ramControl (011,110,111) treated as decode error.
REQ-032 busRData holds last value outside DONE; store completions drive busRData=0.
REQ-033 busReq present in DONE is not accepted; accepted from following IDLE cycle.

Reset
REQ-034 reset low: state IDLE, all outputs 0, counter 0, immediately (asynchronous), including mid-transfer.
REQ-035 Reset release: first transfer accepted on first clk edge with reset high and busReq=1.

Structure
REQ-036 Shared package: state enum, ramControl funct3 constants, region decode constants.
REQ-037 One sub-module, bus_lane_align: combinational PSTRB/PWDATA generation and load extraction/extension.

Verification
REQ-038 SW 0x1000_1004 data 0xDEADBEEF, PREADY=1 immediately -> PSEL=0010, PSTRB=1111, busReady at cycle 3, busErr=0.
REQ-039 LB 0x1000_0003, PRDATA=0x80FF_FF7F -> busRData=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-040 SH 0x1000_2002 data 0x0000_ABCD -> PWDATA=0xABCD_ABCD, PSTRB=1100; LH 0x1000_2001 -> busReady next cycle, busErr=1, PSEL never asserted.
REQ-041 LW slave 3, PREADY held 0 -> busErr=1 after 16 ACCESS cycles, busRData=0; PREADY=1 after 5 wait cycles instead -> normal completion at cycle 8.
REQ-042 Reset asserted in ACCESS -> PSEL, PENABLE, busReady 0 before next edge; next request after release completes normally.
